// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the serial pattern detector controller.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned MIN_LEN = 2;

  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= MIN_LEN) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_shift_match.sv
// Bit history, fill counter and Mealy comparator for the pattern detector.
module seq_shift_match #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din_valid,
  input  logic             din,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             hit
);

  // The live input bit completes the PAT_W window, so only PAT_W-1 past bits are stored.
  logic [PAT_W-2:0] history;
  logic [PAT_W-1:0] cand, mask;
  logic [PAT_W:0]   mask_w;
  logic [LEN_W-1:0] fill;

  assign cand   = {history, din};
  assign mask_w = ({{PAT_W{1'b0}}, 1'b1} << len) - 1'b1;
  assign mask   = mask_w[PAT_W-1:0];
  assign hit    = en & din_valid & (fill >= len - 1'b1) &
                  ((cand & mask) == (pattern & mask));

  always_ff @(posedge clk) begin
    if (!reset) begin
      history <= '0;
      fill    <= '0;
    end else if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (en && din_valid) begin
      if (hit && !overlap) begin
        history <= '0;
        fill    <= '0;
      end else begin
        history <= cand[PAT_W-2:0];
        if (fill < len) fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern detector: config handshake, IDLE/ARMED/DONE FSM, match counter.
// Optional idle timeout in ARMED is built when SEQ_CTRL_TIMEOUT_EN is defined.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int PAT_W   = 8,
  parameter int CNT_W   = 8,
  parameter int TMO_CYC = 16,
  localparam int LEN_W  = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
  input  logic             start,
  input  logic             abort,
  input  logic             din_valid,
  input  logic             din,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
`ifdef SEQ_CTRL_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic             cfg_err
);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] lim_q;
  logic             cfg_bad;
  logic             cfg_take, cfg_ok, arm, lim_hit;
  logic [CNT_W-1:0] cnt_inc;

  assign cfg_take = cfg_valid & cfg_ready;
  assign cfg_ok   = len_legal(32'(cfg_len), PAT_W);
  // A same-cycle offer decides whether start may arm; otherwise the last offer does.
  assign arm      = (state == IDLE) & start & ~abort & (cfg_take ? cfg_ok : ~cfg_bad);
  assign cnt_inc  = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
  assign lim_hit  = y & (lim_q != '0) & (cnt_inc == lim_q);

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_fire;
  assign tmo_fire = (state == ARMED) & ~din_valid & (tmo_cnt == TMO_W'(TMO_CYC - 1));
`endif

  seq_shift_match #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_match (
    .clk       (clk),
    .reset     (reset),
    .clr       (arm),
    .en        (state == ARMED),
    .din_valid (din_valid),
    .din       (din),
    .pattern   (pat_q),
    .len       (len_q),
    .overlap   (ovl_q),
    .hit       (y)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      pat_q     <= '0;
      len_q     <= LEN_W'(MIN_LEN);
      ovl_q     <= 1'b0;
      lim_q     <= '0;
      cfg_bad   <= 1'b0;
      cfg_err   <= 1'b0;
      match_cnt <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
      tmo_cnt   <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      if (cfg_take) begin
        if (cfg_ok) begin
          pat_q   <= cfg_pattern;
          len_q   <= cfg_len;
          ovl_q   <= cfg_overlap;
          lim_q   <= cfg_limit;
          cfg_bad <= 1'b0;
        end else begin
          cfg_bad <= 1'b1;
          cfg_err <= 1'b1;
        end
      end

      if (arm)    match_cnt <= '0;
      else if (y) match_cnt <= cnt_inc;

`ifdef SEQ_CTRL_TIMEOUT_EN
      if (state != ARMED || din_valid) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + 1'b1;
`endif

      case (state)
        IDLE: if (arm) begin
          state     <= ARMED;
          cfg_ready <= 1'b0;
          busy      <= 1'b1;
        end
        ARMED: if (abort) begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end else if (lim_hit) begin
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
`ifdef SEQ_CTRL_TIMEOUT_EN
        end else if (tmo_fire) begin
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          timeout   <= 1'b1;
`endif
        end
        DONE: if (abort || start) begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
          done      <= 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
          timeout   <= 1'b0;
`endif
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 The block SHALL have parameter PAT_W, default 8, meaning maximum pattern length in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning match-counter width.
REQ-003 The block SHALL have parameter TMO_CYC, default 16, meaning idle-timeout length in cycles (used only under REQ-030).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  high only in IDLE; config accepted when cfg_valid & cfg_ready.
REQ-008 cfg_pattern  input  PAT_W  pattern, LSB is the last bit received.
REQ-009 cfg_len  input  $clog2(PAT_W)+1  pattern length, legal 2..PAT_W.
REQ-010 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-011 cfg_limit  input  CNT_W  matches before DONE; 0 = unlimited.
REQ-012 start  input  1  IDLE->ARMED request.
REQ-013 abort  input  1  return to IDLE from any state.
REQ-014 din_valid, din  input  1 each  serial bit stream; a bit is consumed only when din_valid=1.
REQ-015 y  output  1  Mealy match pulse, combinational from din/din_valid and state.
REQ-016 match_cnt  output  CNT_W  saturating match count.
REQ-017 busy  output  1  high in ARMED.
REQ-018 done  output  1  high in DONE.
REQ-019 cfg_err  output  1  sticky; set when an illegal cfg_len is offered.

Function
REQ-020 The FSM SHALL have states IDLE, ARMED, DONE; IDLE->ARMED on start with legal config latched; ARMED->DONE when match_cnt reaches a nonzero cfg_limit; DONE->IDLE on start or abort; any->IDLE on abort.
REQ-021 Config SHALL be latched only on cfg_valid & cfg_ready; cfg_len outside 2..PAT_W SHALL be rejected: config unchanged, cfg_err set, start ignored until a legal config is accepted.
REQ-022 In ARMED, each consumed bit SHALL shift into a PAT_W-bit history and increment a fill counter saturating at cfg_len.
REQ-023 y SHALL equal state==ARMED & din_valid & (fill >= cfg_len-1) & (low cfg_len bits of {history,din} == low cfg_len bits of cfg_pattern), same cycle, no latency.
REQ-024 On a match with cfg_overlap=1 the history SHALL keep shifting; with cfg_overlap=0 history and fill SHALL clear on the same edge.
REQ-025 match_cnt SHALL increment on every y pulse, saturate at 2^CNT_W-1, clear on IDLE->ARMED, and hold its value in DONE.
REQ-026 The match that brings match_cnt to cfg_limit SHALL assert y and move to DONE on the same edge; no further y in DONE.
REQ-027 abort and start asserted together SHALL resolve as abort.
REQ-028 din_valid=0 cycles SHALL neither shift history nor break a partial match.

Reset
REQ-029 With reset=0 at a rising edge: state=IDLE, history=0, fill=0, match_cnt=0, cfg_err=0, stored config pattern=0, len=2, overlap=0, limit=0; y=0, busy=0, done=0, cfg_ready=1 in the next cycle; reset mid-ARMED discards all progress.

Configuration
REQ-030 With SEQ_CTRL_TIMEOUT_EN defined, ARMED SHALL go to DONE and set sticky output timeout (1 bit, cleared on leaving DONE) after TMO_CYC consecutive cycles with din_valid=0; without it, no timeout port or counter SHALL exist and ARMED waits indefinitely.

Structure
REQ-031 Package seq_ctrl_pkg SHALL hold the state enum (IDLE, ARMED, DONE) and the min-length constant 2.
REQ-032 History, fill counter and comparator SHALL be sub-module seq_shift_match; the FSM and counter stay in seq_detect_ctrl.

Verification
REQ-033 Pattern 1001, len 4, overlap=1, stream 1001001 -> y pulses on bit 4 and bit 7, match_cnt=2.
REQ-034 Same stream with overlap=0 -> single y on bit 4, match_cnt=1.
REQ-035 cfg_limit=2, stream 10011001 -> second y on bit 8 in the same cycle as the DONE transition, done=1 the next cycle, later matches ignored.
REQ-036 cfg_len=1 offered -> cfg_err=1, config unchanged, start ignored; then len=4 accepted -> ARMED on start.
REQ-037 reset=0 (active) applied mid-pattern after bits 100 -> IDLE, match_cnt=0, no y on a following 1.
REQ-038 With SEQ_CTRL_TIMEOUT_EN, TMO_CYC=16, 16 idle cycles in ARMED -> done=1, timeout=1; 15 idle cycles then a valid bit -> stays ARMED.
